hex_password_player: RTL and testbench
======================================

// Module: hex_password_player
// PURPOSE
//   Opposite direction of the hex-entry path: takes a stored 16-bit password and replays it
//   as four 4-bit hex digits, MSB nibble first, over a valid/ready handshake.
//   A programmable gap separates the digits.
//   Sits between the password register and the digit display / audit logic.
// PARAMETERS
//   NUM_DIGITS   4    number of nibbles in the password; PW_W = 4*NUM_DIGITS
//   HOLD_CYCLES  16   idle gap in clk cycles after each accepted digit, before the next one is presented; 0 = back-to-back
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      reset, synchronous, active-high
//   load          in   1      1-cycle request: capture password_in and start replay
//   password_in   in   PW_W   password word; digit 0 = bits [PW_W-1 -: 4]
//   busy          out  1      high from the cycle after an accepted load until done
//   digit_out     out  4      current nibble
//   digit_index   out  $clog2(NUM_DIGITS) (min 1)   index of digit_out, 0 = MSB nibble
//   digit_valid   out  1      digit_out/digit_index are valid
//   digit_ready   in   1      consumer accepts when digit_valid && digit_ready
//   done          out  1      1-cycle pulse in the cycle after the last digit is accepted
// BEHAVIOUR
//   Reset (sync, high): state=IDLE, busy=0, digit_valid=0, digit_out=0, digit_index=0, done=0,
//     hold counter=0, shift register=0. Reset wins over every other input in the same cycle.
//   FSM states: IDLE, EMIT, GAP.
//   IDLE: when load=1, capture password_in into the shift register and set idx=0.
//     Next cycle: state=EMIT, busy=1, digit_valid=1.
//     Latency from load to the first digit_valid = 1 cycle.
//   EMIT: digit_out = shreg[PW_W-1 -: 4] and digit_index = idx, both held stable while digit_valid && !digit_ready.
//     On handshake:
//       - idx == NUM_DIGITS-1: go to IDLE, digit_valid=0, busy=0, done=1 for 1 cycle.
//       - else, HOLD_CYCLES > 0: shift left by 4, idx+1, go to GAP, digit_valid=0,
//         hold counter=HOLD_CYCLES-1.
//       - else, HOLD_CYCLES == 0: shift and increment, stay in EMIT, digit_valid stays 1.
//         The next digit is presented in the next cycle.
//   GAP: counter decrements each cycle. When the counter reaches 0, go to EMIT next cycle
//     with digit_valid=1. The gap length is exactly HOLD_CYCLES cycles of digit_valid=0.
//   load while busy: ignored. The current replay is not disturbed and password_in is not sampled.
//   load in the same cycle as done: accepted, because the FSM is back in IDLE.
//     The pulse on done and the new capture coexist.
//   digit_ready while !digit_valid: no effect.
//   Reset mid-replay: returns to IDLE immediately. Remaining digits are discarded and no done pulse occurs.
//   Arithmetic: idx wraps never (bounded by the last-digit check); hold counter width
//     $clog2(HOLD_CYCLES+1), min 1; all outputs registered.
// CONFIGURATION
//   PLAYER_SEG7_EN defined: adds port seg_n [6:0] out (active-low, order g..a).
//     seg_n is a registered 7-segment decode of digit_out for 0-F, updated in the same cycle as digit_out.
//     seg_n = 7'h7F (blank) when digit_valid=0 and at reset.
//   PLAYER_SEG7_EN undefined: port seg_n and the decoder are absent; all other behaviour is identical.
// TESTING
//   1. Reset, then load password_in=16'hA3C5 with digit_ready=1 and HOLD_CYCLES=16.
//      -> digits A,3,C,5 with idx 0..3, each valid 1 cycle, 16-cycle gaps, done 1 cycle after 5, busy low after.
//   2. HOLD_CYCLES=0, password_in=16'h1234, ready=1.
//      -> digit_valid high 4 consecutive cycles with 1,2,3,4; done on the 5th.
//   3. Backpressure: ready=0 for 10 cycles on digit 0 of 16'hBEEF.
//      -> digit_out=B, idx=0 held stable for 10 cycles; the sequence then continues E,E,F.
//   4. Load 16'h0F0F while busy replaying 16'h1111.
//      -> output stays 1,1,1,1; no capture of 0F0F; exactly one done pulse.
//   5. Reset asserted during GAP after digit 1 of 16'h9876.
//      -> next cycle busy=0, valid=0, no done; a later load of 16'h5555 replays 5,5,5,5 from idx 0.
//   6. PLAYER_SEG7_EN: replay 16'h08AF.
//      -> seg_n = 7'h40, 7'h00, 7'h08, 7'h0E in turn; 7'h7F during gaps and idle.

Source files
------------

// File: rtl/hex_password_player.sv
// Replays a stored password as hex digits, MSB nibble first, over valid/ready.
// Optional PLAYER_SEG7_EN adds a registered active-low 7-segment output seg_n.
module hex_password_player #(
    parameter int NUM_DIGITS  = 4,
    parameter int HOLD_CYCLES = 16,
    localparam int PW_W  = 4 * NUM_DIGITS,
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [PW_W-1:0]  password_in,
    output logic             busy,
    output logic [3:0]       digit_out,
    output logic [IDX_W-1:0] digit_index,
    output logic             digit_valid,
    input  logic             digit_ready,
`ifdef PLAYER_SEG7_EN
    output logic [6:0]       seg_n,
`endif
    output logic             done
);

    typedef enum logic [1:0] {IDLE, EMIT, GAP} state_t;

    state_t           state, state_d;
    logic [PW_W-1:0]  shreg, shreg_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             done_d;
    logic             busy_d;
    logic             valid_d;

    assign digit_out   = shreg[PW_W-1 -: 4];
    assign digit_index = idx;

    always_comb begin
        state_d = state;
        shreg_d = shreg;
        idx_d   = idx;
        cnt_d   = cnt;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (load) begin
                    shreg_d = password_in;
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (digit_ready) begin
                    if (idx == IDX_W'(NUM_DIGITS - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = shreg << 4;
                        idx_d   = idx + IDX_W'(1);
                        if (HOLD_CYCLES > 0) begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                        end
                    end
                end
            end
            GAP: begin
                if (cnt == '0) state_d = EMIT;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase
        valid_d = (state_d == EMIT);
        busy_d  = (state_d != IDLE);
    end

`ifdef PLAYER_SEG7_EN
    // Segment order g..a, low = lit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'h0: seg_decode = 7'h40;
            4'h1: seg_decode = 7'h79;
            4'h2: seg_decode = 7'h24;
            4'h3: seg_decode = 7'h30;
            4'h4: seg_decode = 7'h19;
            4'h5: seg_decode = 7'h12;
            4'h6: seg_decode = 7'h02;
            4'h7: seg_decode = 7'h78;
            4'h8: seg_decode = 7'h00;
            4'h9: seg_decode = 7'h10;
            4'hA: seg_decode = 7'h08;
            4'hB: seg_decode = 7'h03;
            4'hC: seg_decode = 7'h46;
            4'hD: seg_decode = 7'h21;
            4'hE: seg_decode = 7'h06;
            default: seg_decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset)        seg_n <= 7'h7F;
        else if (valid_d) seg_n <= seg_decode(shreg_d[PW_W-1 -: 4]);
        else              seg_n <= 7'h7F;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            idx         <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            digit_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            shreg       <= shreg_d;
            idx         <= idx_d;
            cnt         <= cnt_d;
            busy        <= busy_d;
            digit_valid <= valid_d;
            done        <= done_d;
        end
    end

endmodule

// File: tb/tb_hex_password_player.sv
// Bench: two players (16-cycle gap and back-to-back) on shared stimulus,
// each compared every cycle against a digit-queue reference model.
module tb_hex_password_player;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic [15:0] password_in;
    logic        digit_ready;

    logic       busy[2];
    logic [3:0] digit_out[2];
    logic [1:0] digit_index[2];
    logic       digit_valid[2];
    logic       done[2];
`ifdef PLAYER_SEG7_EN
    logic [6:0] seg_n[2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hex_password_player #(.NUM_DIGITS(4), .HOLD_CYCLES(16)) dut_a (
        .clk(clk), .reset(reset), .load(load), .password_in(password_in),
        .busy(busy[0]), .digit_out(digit_out[0]), .digit_index(digit_index[0]),
        .digit_valid(digit_valid[0]), .digit_ready(digit_ready),
`ifdef PLAYER_SEG7_EN
        .seg_n(seg_n[0]),
`endif
        .done(done[0])
    );

    hex_password_player #(.NUM_DIGITS(4), .HOLD_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .load(load), .password_in(password_in),
        .busy(busy[1]), .digit_out(digit_out[1]), .digit_index(digit_index[1]),
        .digit_valid(digit_valid[1]), .digit_ready(digit_ready),
`ifdef PLAYER_SEG7_EN
        .seg_n(seg_n[1]),
`endif
        .done(done[1])
    );

    // Reference model: digits still owed, position, idle cycles before next digit
    int       hold[2] = '{16, 0};
    logic [3:0] m_nib[2][4];
    int       m_left[2];
    int       m_pos[2];
    int       m_wait[2];
    logic     m_done[2];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[d];
    endfunction

    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_left[k] = 0;
                m_pos[k]  = 0;
                m_wait[k] = 0;
                m_done[k] = 1'b0;
            end else begin
                bit was_busy;
                bit showing;
                was_busy  = (m_left[k] > 0);
                showing   = was_busy && (m_wait[k] == 0);
                m_done[k] = 1'b0;
                if (showing && digit_ready) begin
                    m_pos[k]++;
                    m_left[k]--;
                    if (m_left[k] == 0) m_done[k] = 1'b1;
                    else                m_wait[k] = hold[k];
                end else if (was_busy && m_wait[k] > 0) begin
                    m_wait[k]--;
                end
                if (load && !was_busy) begin
                    for (int i = 0; i < 4; i++)
                        m_nib[k][i] = password_in[15-4*i -: 4];
                    m_left[k] = 4;
                    m_pos[k]  = 0;
                    m_wait[k] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            bit v;
            v = (m_left[k] > 0) && (m_wait[k] == 0);
            check($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_left[k] > 0));
            check($sformatf("valid%0d", k), 32'(digit_valid[k]), 32'(v));
            check($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
            if (v) begin
                check($sformatf("digit%0d", k), 32'(digit_out[k]),
                      32'(m_nib[k][m_pos[k]]));
                check($sformatf("index%0d", k), 32'(digit_index[k]), 32'(m_pos[k]));
            end
`ifdef PLAYER_SEG7_EN
            check($sformatf("seg%0d", k), 32'(seg_n[k]),
                  v ? 32'(seg_ref(m_nib[k][m_pos[k]])) : 32'h7F);
`endif
        end
    endtask

    // One clock: inputs are driven at the falling edge, outputs checked at the next one
    task automatic step(input logic rst, input logic ld, input logic [15:0] pw,
                        input logic rdy);
        reset       = rst;
        load        = ld;
        password_in = pw;
        digit_ready = rdy;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, rdy);
    endtask

    initial begin
        reset = 1'b1;
        load = 1'b0;
        password_in = '0;
        digit_ready = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 16'h0, 1'b0);
        step(1'b1, 1'b1, 16'hFFFF, 1'b1);
        for (int k = 0; k < 2; k++) begin
            check("rst_digit", 32'(digit_out[k]), 32'h0);
            check("rst_index", 32'(digit_index[k]), 32'h0);
        end

        step(1'b0, 1'b1, 16'hA3C5, 1'b1);
        idle_cycles(60, 1'b1);

        step(1'b0, 1'b1, 16'h1234, 1'b1);
        idle_cycles(60, 1'b1);

        step(1'b0, 1'b1, 16'hBEEF, 1'b0);
        idle_cycles(10, 1'b0);
        idle_cycles(60, 1'b1);

        step(1'b0, 1'b1, 16'h1111, 1'b1);
        idle_cycles(3, 1'b1);
        step(1'b0, 1'b1, 16'h0F0F, 1'b1);
        idle_cycles(20, 1'b1);
        step(1'b0, 1'b1, 16'h0F0F, 1'b1);
        idle_cycles(40, 1'b1);

        step(1'b0, 1'b1, 16'h9876, 1'b1);
        idle_cycles(22, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        idle_cycles(3, 1'b1);
        step(1'b0, 1'b1, 16'h5555, 1'b1);
        idle_cycles(60, 1'b1);

        step(1'b0, 1'b1, 16'h08AF, 1'b1);
        idle_cycles(60, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            logic rst_r, ld_r, rdy_r;
            rst_r = ($urandom_range(0, 299) == 0);
            ld_r  = ($urandom_range(0, 11) == 0);
            rdy_r = ($urandom_range(0, 3) != 0);
            step(rst_r, ld_r, 16'($urandom), rdy_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
